// File: rtl/core_pkg.sv
// Shared constants for the pipeline hazard and data-memory control path.
// Forwarding selects, result-source codes and mem-ctrl state encoding.
package core_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_mem_ctrl_forward_unit.sv
// EX-stage operand forwarding select.
// Memory-stage results win over writeback; x0 is never forwarded.
module forward_unit
  import core_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       we_m,
    input logic       we_w
  );
    logic [1:0] s;
    s = FWD_RF;
    if (we_m && rd_m != 5'd0 && rd_m == rs)
      s = FWD_MEM;
    else if (we_w && rd_w != 5'd0 && rd_w == rs)
      s = FWD_WB;
    return s;
  endfunction

  always_comb begin
    fwd_a = sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    fwd_b = sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  end

endmodule

// File: rtl/hazard_mem_ctrl.sv
// Pipeline sequencing: forwarding, load-use stall, branch flush and
// the data-memory wait/timeout handshake with a stall-cycle counter.
module hazard_mem_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic [1:0]  ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        mem_fault,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_fault_q, mem_fault_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall;
  logic       mem_stall;
  logic       req;
  logic       any_stall;

  forward_unit u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  always_comb begin
    lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0)
            && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    mem_stall   = 1'b0;
    req         = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        req = MemReqM;
        if (MemReqM && !dmem_ready) begin
          state_d    = MC_WAIT;
          wait_cnt_d = CNT_W'(1);
          mem_stall  = 1'b1;
        end
      end
      MC_WAIT: begin
        req = 1'b1;
        if (dmem_ready) begin
          state_d    = MC_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO) begin
          // Abandon the access: let the instruction retire, flag it.
          state_d     = MC_IDLE;
          wait_cnt_d  = '0;
          mem_fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          mem_stall  = 1'b1;
        end
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  always_comb begin
    dmem_req  = !rst && req;
    ForwardAE = rst ? FWD_RF : fwd_a;
    ForwardBE = rst ? FWD_RF : fwd_b;
    StallF    = !rst && (lw_stall || mem_stall);
    StallD    = StallF;
    StallE    = !rst && mem_stall;
    StallM    = StallE;
    FlushW    = StallE;
    FlushD    = !rst && PCSrcE && !mem_stall;
    FlushE    = !rst && (lw_stall || PCSrcE) && !mem_stall;
    any_stall = StallF || StallM;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (any_stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MC_IDLE;
      wait_cnt_q     <= '0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_fault    = mem_fault_q;
  assign stall_cycles = stall_cycles_q;

endmodule
